fft_frame_buffer: RTL

Upstream producer for `FFT_Processor`. It accepts a serial stream of 16-bit audio samples over a valid/ready handshake and assembles them into 16-sample frames. When the FFT is idle, it presents a frame on the parallel `t0..t15` bus, pulses `new_t`, and holds the frame until the FFT returns `done`. A capture buffer keeps filling while the FFT works, so the sample stream stalls only when a full frame is waiting on a busy FFT.

---
 rtl/fft_frame_pkg.sv | 17 +
 rtl/fft_sample_capture.sv | 62 ++++++
 rtl/fft_frame_buffer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fft_frame_pkg.sv
// Shared constants and types for the FFT frame buffer: frame size, default
// sample width and the issue FSM state encoding.
package fft_frame_pkg;

  localparam int FFT_N        = 16;
  localparam int HALF_N       = FFT_N / 2;
  localparam int IDX_W        = $clog2(FFT_N);
  localparam int SAMPLE_W_DEF = 16;

  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } frame_state_e;

endpackage

// File: rtl/fft_sample_capture.sv
// Capture buffer: collects serial samples into a 16-entry frame.
// FFT_FRAME_OVERLAP_EN keeps the newest half of the frame on every issue.
module fft_sample_capture
  import fft_frame_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       issue,
  output logic                       capture_full,
  output logic signed [SAMPLE_W-1:0] capture [FFT_N]
);

`ifdef FFT_FRAME_OVERLAP_EN
  localparam logic [IDX_W-1:0] RESTART_IDX = IDX_W'(HALF_N);
`else
  localparam logic [IDX_W-1:0] RESTART_IDX = '0;
`endif

  logic [IDX_W-1:0] wr_idx;
  logic             accept;

  assign accept = in_valid && in_ready;

  // in_ready is registered alongside capture_full so it never depends on in_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx       <= '0;
      capture_full <= 1'b0;
      in_ready     <= 1'b1;
    end else if (issue) begin
      wr_idx       <= RESTART_IDX;
      capture_full <= 1'b0;
      in_ready     <= 1'b1;
    end else if (accept) begin
      wr_idx <= wr_idx + 1'b1;
      if (wr_idx == IDX_W'(FFT_N - 1)) begin
        capture_full <= 1'b1;
        in_ready     <= 1'b0;
      end
    end
  end

  // Sample storage carries no reset; wr_idx alone decides what is valid
  always_ff @(posedge clk) begin
    if (accept) begin
      capture[wr_idx] <= in_sample;
    end
`ifdef FFT_FRAME_OVERLAP_EN
    else if (issue) begin
      for (int i = 0; i < HALF_N; i++) begin
        capture[i] <= capture[i + HALF_N];
      end
    end
`endif
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Frame producer for FFT_Processor: issues captured 16-sample frames and waits
// for done with a timeout. Optional FFT_FRAME_OVERLAP_EN selects 50% overlap.
module fft_frame_buffer
  import fft_frame_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [SAMPLE_W-1:0] t0,
  output logic signed [SAMPLE_W-1:0] t1,
  output logic signed [SAMPLE_W-1:0] t2,
  output logic signed [SAMPLE_W-1:0] t3,
  output logic signed [SAMPLE_W-1:0] t4,
  output logic signed [SAMPLE_W-1:0] t5,
  output logic signed [SAMPLE_W-1:0] t6,
  output logic signed [SAMPLE_W-1:0] t7,
  output logic signed [SAMPLE_W-1:0] t8,
  output logic signed [SAMPLE_W-1:0] t9,
  output logic signed [SAMPLE_W-1:0] t10,
  output logic signed [SAMPLE_W-1:0] t11,
  output logic signed [SAMPLE_W-1:0] t12,
  output logic signed [SAMPLE_W-1:0] t13,
  output logic signed [SAMPLE_W-1:0] t14,
  output logic signed [SAMPLE_W-1:0] t15,
  output logic                       new_t,
  input  logic                       done,
  output logic                       busy,
  output logic [15:0]                frame_count,
  output logic                       timeout
);

  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  frame_state_e               state, state_nxt;
  logic                       capture_full;
  logic                       issue;
  logic                       done_ok;
  logic                       expire;
  logic [TMO_W-1:0]           tmo_cnt;
  logic signed [SAMPLE_W-1:0] capture [FFT_N];
  logic signed [SAMPLE_W-1:0] t_q     [FFT_N];

  fft_sample_capture #(
    .SAMPLE_W (SAMPLE_W)
  ) u_capture (
    .clk          (clk),
    .rst          (rst),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .issue        (issue),
    .capture_full (capture_full),
    .capture      (capture)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (capture_full)      state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_ok || expire) state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // done during the new_t cycle belongs to the previous frame and is dropped
  always_comb begin
    busy    = (state == WAIT_DONE);
    issue   = (state == IDLE) && capture_full;
    done_ok = busy && done && !new_t;
    expire  = busy && (tmo_cnt == TMO_W'(DONE_TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_t       <= 1'b0;
      frame_count <= '0;
      timeout     <= 1'b0;
      tmo_cnt     <= '0;
      for (int i = 0; i < FFT_N; i++) t_q[i] <= '0;
    end else begin
      new_t <= issue;
      if (issue) begin
        frame_count <= frame_count + 1'b1;
        tmo_cnt     <= '0;
        for (int i = 0; i < FFT_N; i++) t_q[i] <= capture[i];
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (expire && !done_ok) timeout <= 1'b1;
    end
  end

  assign t0  = t_q[0];
  assign t1  = t_q[1];
  assign t2  = t_q[2];
  assign t3  = t_q[3];
  assign t4  = t_q[4];
  assign t5  = t_q[5];
  assign t6  = t_q[6];
  assign t7  = t_q[7];
  assign t8  = t_q[8];
  assign t9  = t_q[9];
  assign t10 = t_q[10];
  assign t11 = t_q[11];
  assign t12 = t_q[12];
  assign t13 = t_q[13];
  assign t14 = t_q[14];
  assign t15 = t_q[15];

endmodule
